// File: rtl/adc_multi_average_pkg.sv
// Shared definitions for the multi-channel ADC averager: default widths,
// FSM state type and accumulator sizing.
package adc_pkg;

    localparam int unsigned ADC_WIDTH_DEF = 12;
    localparam int unsigned MAX_LOG2_DEF  = 10;

    typedef enum logic {
        IDLE,
        ACCUM
    } ave_state_t;

    // A full 2^max_log2 window of extreme samples, plus the rounding constant, fits.
    function automatic int unsigned acc_width(input int unsigned adc_w,
                                              input int unsigned max_log2);
        return adc_w + max_log2;
    endfunction

endpackage

// File: rtl/adc_multi_average_channel.sv
// Single-channel boxcar accumulator with arithmetic-shift output stage.
// Optional rounding (half toward +inf) when ADC_AVERAGE_ROUND_EN is defined.
module adc_ave_channel
    import adc_pkg::*;
#(
    parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF,
    parameter int unsigned MAX_LOG2  = MAX_LOG2_DEF,
    parameter int unsigned LOG2_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 accept,
    input  logic                 last,
    input  logic [LOG2_W-1:0]    log2,
    input  logic [ADC_WIDTH-1:0] sample,
    output logic [ADC_WIDTH-1:0] ave
);

    localparam int unsigned AW = acc_width(ADC_WIDTH, MAX_LOG2);

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] total;

    assign ext = {{MAX_LOG2{sample[ADC_WIDTH-1]}}, sample};
    assign sum = acc_q + ext;

`ifdef ADC_AVERAGE_ROUND_EN
    logic signed [AW-1:0] rnd;
    assign rnd   = (log2 == '0) ? '0 : (AW'(1) << (log2 - LOG2_W'(1)));
    assign total = sum + rnd;
`else
    assign total = sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            ave   <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (accept) begin
            if (last) begin
                // Restart at zero on the closing edge so continuous windows abut.
                acc_q <= '0;
                ave   <= ADC_WIDTH'(total >>> log2);
            end else begin
                acc_q <= sum;
            end
        end
    end

endmodule

// File: rtl/adc_multi_average.sv
// NUM_CH-channel power-of-two boxcar averager with one-shot/continuous modes.
// Build option: ADC_AVERAGE_ROUND_EN selects round-half-up instead of floor.
module adc_multi_average
    import adc_pkg::*;
#(
    parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned MAX_LOG2  = MAX_LOG2_DEF,
    parameter int unsigned LOG2_W    = 4
) (
    input  logic                        ADC_CLK,
    input  logic                        RESET,
    input  logic [NUM_CH*ADC_WIDTH-1:0] ADC_DATA_IN,
    input  logic                        SAMPLE_VALID,
    input  logic                        START,
    input  logic                        CONTINUOUS,
    input  logic [LOG2_W-1:0]           AVE_LOG2,
    output logic [NUM_CH*ADC_WIDTH-1:0] AVE_OUT,
    output logic                        AVE_VALID,
    output logic                        BUSY,
    output logic                        DONE
);

    ave_state_t state_q, state_d;

    logic [MAX_LOG2-1:0] count_q;
    logic [MAX_LOG2-1:0] last_idx;
    logic [LOG2_W-1:0]   l_q;
    logic [LOG2_W-1:0]   l_clamped;
    logic                cont_q;
    logic                accept;
    logic                last;

    assign l_clamped = (AVE_LOG2 > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : AVE_LOG2;
    assign last_idx  = ~({MAX_LOG2{1'b1}} << l_q);

    // START takes priority over any sample, including a window-closing one.
    assign accept = (state_q == ACCUM) && SAMPLE_VALID && !START;
    assign last   = accept && (count_q == last_idx);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = ACCUM;
            ACCUM: begin
                if (START)
                    state_d = ACCUM;
                else if (last && !cont_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            count_q   <= '0;
            l_q       <= '0;
            cont_q    <= 1'b0;
            AVE_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state_q   <= state_d;
            BUSY      <= (state_d == ACCUM);
            AVE_VALID <= last;
            if (START) begin
                l_q     <= l_clamped;
                cont_q  <= CONTINUOUS;
                count_q <= '0;
                DONE    <= 1'b0;
            end else if (accept) begin
                count_q <= last ? '0 : count_q + MAX_LOG2'(1);
                if (last)
                    DONE <= 1'b1;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        adc_ave_channel #(
            .ADC_WIDTH (ADC_WIDTH),
            .MAX_LOG2  (MAX_LOG2),
            .LOG2_W    (LOG2_W)
        ) u_ch (
            .clk    (ADC_CLK),
            .reset  (RESET),
            .clear  (START),
            .accept (accept),
            .last   (last),
            .log2   (l_q),
            .sample (ADC_DATA_IN[ch*ADC_WIDTH +: ADC_WIDTH]),
            .ave    (AVE_OUT[ch*ADC_WIDTH +: ADC_WIDTH])
        );
    end

endmodule

// File: tb/tb_adc_multi_average.sv
// Scoreboard bench for adc_multi_average: window-sum reference model feeds an
// expected-result queue that a posedge monitor drains.
module tb_adc_multi_average;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_in;
    logic        sample_valid;
    logic        start;
    logic        continuous;
    logic [3:0]  ave_log2;
    logic [23:0] ave_out;
    logic        ave_valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    adc_multi_average #(
        .ADC_WIDTH (12),
        .NUM_CH    (2),
        .MAX_LOG2  (10),
        .LOG2_W    (4)
    ) dut (
        .ADC_CLK      (clk),
        .RESET        (rst),
        .ADC_DATA_IN  (data_in),
        .SAMPLE_VALID (sample_valid),
        .START        (start),
        .CONTINUOUS   (continuous),
        .AVE_LOG2     (ave_log2),
        .AVE_OUT      (ave_out),
        .AVE_VALID    (ave_valid),
        .BUSY         (busy),
        .DONE         (done)
    );

    typedef struct {
        int due;
        int v0;
        int v1;
    } exp_t;

    exp_t sb[$];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model state: what the outputs should read after the next edge.
    bit     m_active;
    int     m_L;
    bit     m_cont;
    int     m_n;
    longint m_sum0, m_sum1;
    bit     exp_busy, exp_done;
    int     held0, held1;

    function automatic int window_avg(input longint s, input int L);
        longint d, q, v;
        d = longint'(1) << L;
        v = s;
`ifdef ADC_AVERAGE_ROUND_EN
        if (L > 0) v = v + d / 2;
`endif
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return int'(q);
    endfunction

    function automatic int rand_sample();
        int r;
        r = int'($urandom_range(0, 4095));
        return (r >= 2048) ? r - 4096 : r;
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void model_step(input bit r, input bit st, input bit cont,
                                       input int lg, input bit vld,
                                       input int s0, input int s1);
        exp_t e;
        if (r) begin
            m_active = 0; m_n = 0; m_sum0 = 0; m_sum1 = 0;
            exp_done = 0; held0 = 0; held1 = 0;
        end else if (st) begin
            m_active = 1;
            m_L      = (lg > 10) ? 10 : lg;
            m_cont   = cont;
            m_n = 0; m_sum0 = 0; m_sum1 = 0;
            exp_done = 0;
        end else if (m_active && vld) begin
            m_sum0 += s0;
            m_sum1 += s1;
            m_n++;
            if (m_n == (1 << m_L)) begin
                e.due = cyc + 1;
                e.v0  = window_avg(m_sum0, m_L);
                e.v1  = window_avg(m_sum1, m_L);
                sb.push_back(e);
                held0 = e.v0;
                held1 = e.v1;
                exp_done = 1;
                m_n = 0; m_sum0 = 0; m_sum1 = 0;
                if (!m_cont) m_active = 0;
            end
        end
        exp_busy = m_active;
    endfunction

    // Drives one cycle of stimulus, updates the model, then advances past the edge.
    task automatic step(input bit r, input bit st, input bit cont, input int lg,
                        input bit vld, input int s0, input int s1);
        logic [11:0] a, b;
        a = s0[11:0];
        b = s1[11:0];
        rst          = r;
        start        = st;
        continuous   = cont;
        ave_log2     = lg[3:0];
        sample_valid = vld;
        data_in      = {b, a};
        model_step(r, st, cont, lg, vld, s0, s1);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, $urandom_range(0, 1), int'($urandom_range(0, 15)), 0, rand_sample(), rand_sample());
    endtask

    // Monitor: checks every cycle; pops the scoreboard when the DUT presents a result.
    always begin
        bit   due;
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        due = (sb.size() > 0) && (sb[0].due == cyc);
        chk("ave_valid", int'(ave_valid), int'(due));
        if (ave_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("ave_ch0", int'($signed(ave_out[11:0])), e.v0);
            chk("ave_ch1", int'($signed(ave_out[23:12])), e.v1);
        end else if (due) begin
            void'(sb.pop_front());
        end
        chk("busy", int'(busy), int'(exp_busy));
        chk("done", int'(done), int'(exp_done));
        chk("held_ch0", int'($signed(ave_out[11:0])), held0);
        chk("held_ch1", int'($signed(ave_out[23:12])), held1);
    end

    initial begin
        int v;
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 100, 100);
        idle(2);

        // One-shot L=2: 1,2,3,4 and -4 x4
        step(0, 1, 0, 2, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 7, 1, i, -4);
        idle(3);

        // Continuous L=10 ramp 0..2047, no gaps
        step(0, 1, 1, 10, 0, 0, 0);
        for (int i = 0; i < 2048; i++) step(0, 0, 0, 0, 1, i, rand_sample());

        // L=0 back-to-back samples; START also ends the continuous run
        step(0, 1, 0, 0, 1, 9, 9);
        step(0, 0, 0, 0, 1, 5, -1);
        step(0, 0, 0, 0, 1, -7, 2047);
        step(0, 0, 0, 0, 1, 100, -2048);
        idle(2);

        // Clamp AVE_LOG2=15 to 1024-sample window, full-scale inputs
        step(0, 1, 0, 15, 0, 0, 0);
        for (int i = 0; i < 1024; i++) step(0, 0, 0, 0, 1, 2047, -2048);
        idle(3);

        // START coincident with 4th sample aborts the window
        step(0, 1, 0, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 50, 60);
        step(0, 1, 0, 2, 1, 70, 80);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 10 + i, -10 - i);
        idle(2);

        // RESET mid-window, then L=1 with 6,8
        step(0, 1, 0, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 300, 300);
        step(1, 0, 0, 0, 1, 300, 300);
        step(1, 0, 0, 0, 1, 300, 300);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6, -3);
        step(0, 0, 0, 0, 1, 8, -5);
        idle(2);

        // Randomized: stalls, restarts, rare resets, config noise off-START
        for (int i = 0; i < 2500; i++) begin
            bit r, st;
            v  = int'($urandom_range(0, 999));
            r  = (v < 2);
            st = !r && ((!m_active && v < 120) || (v >= 990));
            step(r, st, $urandom_range(0, 1), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) < 7), rand_sample(), rand_sample());
        end
        idle(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
